mult_seq_32: RTL and testbench

- Multi-cycle 32x32 integer multiplier for the integer datapath ALU; the inverse operation of the divide unit.
- Produces a 64-bit product split into hi/lo words, for MULT/MULTU and HI/LO writeback.
- Uses a shift-add algorithm, one multiplier bit per clock, under a start/done handshake so the datapath can stall on busy.

---
 rtl/mult_seq_32.sv | 111 +++++++++++
 tb/tb_mult_seq_32.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_32.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_32
// Purpose  : Multi-cycle shift-add 32x32 multiplier (MULT/MULTU) with a
//            start/done handshake and a 64-bit product split into hi/lo words.
// Revision : 1.0  initial release
// ============================================================================
module mult_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg;
    logic [WIDTH-1:0]     r_prod_hi;
    logic [WIDTH-1:0]     r_prod_lo;

    logic                 w_last;
    logic [WIDTH-1:0]     w_s_mag;
    logic [WIDTH-1:0]     w_t_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_prod;

    // Unsigned magnitudes; the most negative value maps onto itself.
    assign w_s_mag = (sgn && S[WIDTH-1]) ? -S : S;
    assign w_t_mag = (sgn && T[WIDTH-1]) ? -T : T;

    // The multiplier lives in the low half of the accumulator and is consumed
    // from bit 0 while partial products shift in from above; w_sum carries
    // the extra accumulator bit.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_acc_next : w_acc_next;

    assign w_last = (r_cnt == c_CNT_W'(WIDTH-1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_FIN;
            ST_FIN:              w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= w_s_mag;
                        r_acc   <= {{WIDTH{1'b0}}, w_t_mag};
                        r_neg   <= sgn & (S[WIDTH-1] ^ T[WIDTH-1]);
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        r_prod_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_prod_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_FIN);
    assign prod_hi = r_prod_hi;
    assign prod_lo = r_prod_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_32
// Purpose  : Self-checking bench for mult_seq_32: directed vectors, handshake
//            and reset corner cases, and random operands against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_seq_32;

    localparam int c_W       = 32;
    // Edges from the accepting edge (counted as edge 1) to the first edge
    // after which done is seen.
    localparam int c_LAT     = c_W + 1;
    localparam int c_PERIOD  = c_W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sgn;
    logic [c_W-1:0] s;
    logic [c_W-1:0] t;
    logic          busy;
    logic          done;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_seq_32 #(.WIDTH(c_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sgn     (sgn),
        .S       (s),
        .T       (t),
        .busy    (busy),
        .done    (done),
        .prod_hi (hi),
        .prod_lo (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           sg;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [63:0]    p;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact product from plain 64-bit arithmetic on extended operands.
    function automatic logic [63:0] ref_mul(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Launch one op from IDLE and wait for done. inj_at > 0 pulses a second
    // start (S=2, T=2) after that many edges, which must be ignored.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, output logic [63:0] prod, output int lat);
        logic busy_bad;
        busy_bad = 1'b0;
        sgn = sg; s = a; t = b; start = 1'b1;
        tick();
        lat = 1;
        start = 1'b0;
        s = $urandom; t = $urandom; sgn = ~sg;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (inj_at != 0 && lat == inj_at) begin
                start = 1'b1; s = 32'd2; t = 32'd2; sgn = 1'b0;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        prod = {hi, lo};
        check("busy_during_run", {63'b0, busy_bad}, 64'd0);
        check("busy_in_fin", {63'b0, busy}, 64'd1);
        tick();
        check("done_one_cycle", {63'b0, done}, 64'd0);
        check("idle_after_fin", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] p2;
        int          lat;
        int          d1;
        int          d2;
        int          e;
        int          n_done;
        int          n_busy;
        logic        bad;

        vecs[0] = '{1'b0, 32'd7,        32'd6,        64'h0000_0000_0000_002A};
        vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'd5,        64'h0000_0004_FFFF_FFF1};
        vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[4] = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000};
        vecs[5] = '{1'b1, 32'h80000000, 32'd1,        64'hFFFF_FFFF_8000_0000};
        vecs[6] = '{1'b1, 32'd0,        32'hFFFFFFFF, 64'h0000_0000_0000_0000};
        vecs[7] = '{1'b0, 32'd1,        32'hFFFFFFFF, 64'h0000_0000_FFFF_FFFF};
        vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000_0000_0000_0001};
        vecs[9] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000_0000_8000_0000};

        reset = 1'b1; start = 1'b0; sgn = 1'b0; s = '0; t = '0;
        repeat (3) tick();
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_prod", {hi, lo}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].sg, vecs[i].a, vecs[i].b, 0, prod, lat);
            check($sformatf("vec%0d_prod", i), prod, vecs[i].p);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(c_LAT));
        end

        // start re-asserted mid-RUN is ignored
        run_op(1'b0, 32'd9, 32'd9, 5, prod, lat);
        check("inject_prod", prod, 64'h51);
        check("inject_latency", 64'(lat), 64'(c_LAT));
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        check("inject_extra_done", 64'(n_done), 64'd0);
        check("inject_extra_busy", 64'(n_busy), 64'd0);

        // start held high: back-to-back ops every c_PERIOD edges
        sgn = 1'b0; s = 32'h10; t = 32'h20; start = 1'b1;
        d1 = 0; d2 = 0; p2 = '0; prod = '0; e = 0;
        while (d2 == 0 && e < 100) begin
            tick();
            e++;
            if (done === 1'b1) begin
                if (d1 == 0) begin
                    d1 = e; prod = {hi, lo};
                end else begin
                    d2 = e; p2 = {hi, lo};
                end
            end
        end
        start = 1'b0;
        tick();
        check("held_first_done", 64'(d1), 64'(c_LAT));
        check("held_second_done", 64'(d2), 64'(c_LAT + c_PERIOD));
        check("held_first_prod", prod, 64'h200);
        check("held_second_prod", p2, 64'h200);

        // Reset during RUN abandons the op
        sgn = 1'b0; s = 32'h1234; t = 32'h10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_reset_busy", {63'b0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_done", {63'b0, done}, 64'd0);
        check("midreset_prod", {hi, lo}, 64'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("midreset_no_done", 64'(n_done), 64'd0);
        run_op(1'b0, 32'd3, 32'd4, 0, prod, lat);
        check("after_reset_prod", prod, 64'hC);
        check("after_reset_latency", 64'(lat), 64'(c_LAT));

        // Result holds while inputs wander with start low
        run_op(1'b0, 32'd5, 32'd5, 0, prod, lat);
        check("hold_first", prod, 64'h19);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            s = $urandom; t = $urandom; sgn = 1'($urandom);
            tick();
            if ({hi, lo} !== 64'h19 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("hold_stable", {63'b0, bad}, 64'd0);

        // Random operands against the model
        for (int i = 0; i < 40; i++) begin
            logic        rs;
            logic [31:0] ra;
            logic [31:0] rb;
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 1) ra = 32'h80000000;
            if (i % 8 == 3) rb = 32'hFFFFFFFF;
            if (i % 8 == 5) ra = 32'd0;
            run_op(rs, ra, rb, 0, prod, lat);
            check($sformatf("rand%0d_sg%0d_%h_%h", i, rs, ra, rb), prod, ref_mul(rs, ra, rb));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(c_LAT));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
